// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: default constants,
// fetch FSM states and the instruction-queue entry layout.
package fetch_stage_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0040_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    START,
    FETCH,
    DROP
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } fetch_entry_t;

  // Instruction addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched instructions. Entry 0 is always the head, so a
// pop shifts entry 1 down. Flush empties the queue and wins over push/pop.
module fetch_queue
  import fetch_stage_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t entry0_q, entry1_q;
  logic [1:0]   count_q;
  logic         do_push, do_pop;

  // Ignore pops of an empty queue and pushes into a full one that is not draining.
  always_comb begin
    do_pop  = pop && (count_q != 2'd0);
    do_push = push && ((count_q != 2'd2) || do_pop);
  end

  // Storage and occupancy update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry0_q <= '0;
      entry1_q <= '0;
      count_q  <= 2'd0;
    end else if (flush) begin
      count_q <= 2'd0;
    end else if (do_push && do_pop) begin
      if (count_q == 2'd1) begin
        entry0_q <= push_entry;
      end else begin
        entry0_q <= entry1_q;
        entry1_q <= push_entry;
      end
    end else if (do_pop) begin
      entry0_q <= entry1_q;
      count_q  <= count_q - 2'd1;
    end else if (do_push) begin
      if (count_q == 2'd0) begin
        entry0_q <= push_entry;
      end else begin
        entry1_q <= push_entry;
      end
      count_q <= count_q + 2'd1;
    end
  end

  assign count = count_q;
  assign head  = entry0_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, runs the imem req/ack handshake and feeds IF/ID from
// a 2-entry instruction queue. Stalls hold the queue head on the outputs.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC4_out,
  output logic [31:0] Instruction_out,
  output logic        fetch_busy
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         req_q, req_d;
  logic [31:0]  addr_q, addr_d;

  logic         q_push, q_pop, q_flush;
  logic [1:0]   q_count, count_next;
  fetch_entry_t q_head, q_push_entry;

  logic         complete;
  logic [31:0]  pc_inc, target;

  assign complete     = req_q && imem_ack;
  assign pc_inc       = pc_q + 32'd4;
  assign target       = word_align(redirect_target);
  assign q_push_entry = '{pc4: pc_inc, instr: imem_rdata};

  fetch_queue u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (q_push),
    .push_entry (q_push_entry),
    .pop        (q_pop),
    .flush      (q_flush),
    .count      (q_count),
    .head       (q_head)
  );

  // Next-state logic: FSM, PC, request register and queue controls.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    q_push     = 1'b0;
    q_pop      = (q_count != 2'd0) && !stall;
    q_flush    = 1'b0;
    count_next = q_count;

    unique case (state_q)
      START: begin
        state_d = FETCH;
        req_d   = 1'b1;
        addr_d  = pc_q;
      end

      FETCH: begin
        if (redirect) begin
          // Head is the delay slot and was captured by IF/ID; the rest is dead.
          q_flush = 1'b1;
          pc_d    = target;
          if (req_q && !imem_ack) begin
            state_d = DROP;
          end else begin
            req_d  = 1'b1;
            addr_d = target;
          end
        end else begin
          if (complete) begin
            q_push = 1'b1;
            pc_d   = pc_inc;
          end
          count_next = q_count + {1'b0, q_push} - {1'b0, q_pop};
          // An in-flight request stays frozen until its ack.
          if (!req_q || complete) begin
            req_d  = (count_next < 2'd2);
            addr_d = pc_d;
          end
        end
      end

      DROP: begin
        if (redirect) begin
          q_flush = 1'b1;
          pc_d    = target;
        end
        // The stale word is discarded; restart at the latest target.
        if (complete) begin
          state_d = FETCH;
          req_d   = 1'b1;
          addr_d  = pc_d;
        end
      end

      default: state_d = START;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= START;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  assign imem_req        = req_q;
  assign imem_addr       = addr_q;
  assign fetch_busy      = (q_count == 2'd0);
  assign PC4_out         = fetch_busy ? 32'd0 : q_head.pc4;
  assign Instruction_out = fetch_busy ? NOP_INSTR : q_head.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-programmable instruction memory.
module tb_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_5A5A;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] PC4_out;
  logic [31:0] Instruction_out;
  logic        fetch_busy;

  int tests = 0;
  int failed = 0;

  // Memory model controls.
  int          lat = 1;
  int          wait_cnt = 0;
  bit          auto_mem = 1'b1;
  logic        man_ack = 1'b0;
  logic [31:0] man_rdata = 32'd0;

  fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .PC4_out         (PC4_out),
    .Instruction_out (Instruction_out),
    .fetch_busy      (fetch_busy)
  );

  always #5 clk = ~clk;

  // Memory: acks after req has been high for lat cycles (lat=1 acks with the req).
  always @(negedge clk) begin
    if (auto_mem) begin
      if (imem_req) begin
        if (wait_cnt >= lat - 1) begin
          imem_ack   = 1'b1;
          imem_rdata = imem_addr ^ KEY;
          wait_cnt   = 0;
        end else begin
          imem_ack = 1'b0;
          wait_cnt = wait_cnt + 1;
        end
      end else begin
        imem_ack = 1'b0;
        wait_cnt = 0;
      end
    end else begin
      imem_ack   = man_ack;
      imem_rdata = man_rdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    tests++;
    if ({imem_req, imem_addr} !== {1'b0, 32'h0040_0000}) begin
      failed++;
      $display("FAIL reset_req_addr: got %h want %h", {imem_req, imem_addr}, {1'b0, 32'h0040_0000});
    end
    tests++;
    if ({PC4_out, Instruction_out, fetch_busy} !== {32'd0, 32'd0, 1'b1}) begin
      failed++;
      $display("FAIL reset_outputs: got %h want %h", {PC4_out, Instruction_out, fetch_busy},
               {32'd0, 32'd0, 1'b1});
    end
    reset = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] pc4;
    tick();
    tests++;
    if ({imem_req, imem_addr, fetch_busy} !== {1'b1, 32'h0040_0000, 1'b1}) begin
      failed++;
      $display("FAIL stream_first_req: got %h want %h", {imem_req, imem_addr, fetch_busy},
               {1'b1, 32'h0040_0000, 1'b1});
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      pc4 = 32'h0040_0000 + 32'(4 * i);
      tests++;
      if ({PC4_out, Instruction_out, fetch_busy, imem_req, imem_addr} !==
          {pc4, (pc4 - 32'd4) ^ KEY, 1'b0, 1'b1, pc4}) begin
        failed++;
        $display("FAIL stream_%0d: got %h want %h", i,
                 {PC4_out, Instruction_out, fetch_busy, imem_req, imem_addr},
                 {pc4, (pc4 - 32'd4) ^ KEY, 1'b0, 1'b1, pc4});
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({imem_req, PC4_out, Instruction_out, fetch_busy} !==
          {1'b0, 32'h0040_0014, 32'h0040_0010 ^ KEY, 1'b0}) begin
        failed++;
        $display("FAIL stall_hold_%0d: got %h want %h", i,
                 {imem_req, PC4_out, Instruction_out, fetch_busy},
                 {1'b0, 32'h0040_0014, 32'h0040_0010 ^ KEY, 1'b0});
      end
    end
    stall = 1'b0;
    tick();
    tests++;
    if ({PC4_out, Instruction_out, imem_req, imem_addr} !==
        {32'h0040_0018, 32'h0040_0014 ^ KEY, 1'b1, 32'h0040_0018}) begin
      failed++;
      $display("FAIL stall_release_pop: got %h want %h", {PC4_out, Instruction_out, imem_req, imem_addr},
               {32'h0040_0018, 32'h0040_0014 ^ KEY, 1'b1, 32'h0040_0018});
    end
    tick();
    tests++;
    if ({PC4_out, Instruction_out, fetch_busy} !== {32'h0040_001C, 32'h0040_0018 ^ KEY, 1'b0}) begin
      failed++;
      $display("FAIL stall_release_next: got %h want %h", {PC4_out, Instruction_out, fetch_busy},
               {32'h0040_001C, 32'h0040_0018 ^ KEY, 1'b0});
    end
  endtask

  task automatic test_latency();
    logic [31:0] exp_pc4  [6] = '{32'h0, 32'h0, 32'h0040_0020, 32'h0, 32'h0, 32'h0040_0024};
    logic [31:0] exp_addr [6] = '{32'h0040_001C, 32'h0040_001C, 32'h0040_0020,
                                  32'h0040_0020, 32'h0040_0020, 32'h0040_0024};
    logic [31:0] exp_instr;
    lat = 3;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_instr = (exp_pc4[i] == 32'd0) ? 32'd0 : ((exp_pc4[i] - 32'd4) ^ KEY);
      tests++;
      if ({PC4_out, Instruction_out, fetch_busy, imem_req, imem_addr} !==
          {exp_pc4[i], exp_instr, exp_pc4[i] == 32'd0, 1'b1, exp_addr[i]}) begin
        failed++;
        $display("FAIL latency_%0d: got %h want %h", i,
                 {PC4_out, Instruction_out, fetch_busy, imem_req, imem_addr},
                 {exp_pc4[i], exp_instr, exp_pc4[i] == 32'd0, 1'b1, exp_addr[i]});
      end
    end
  endtask

  task automatic test_redirect_drop();
    redirect        = 1'b1;
    redirect_target = 32'h0040_0103;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tests++;
      if ({imem_req, imem_addr, PC4_out, Instruction_out, fetch_busy} !==
          {1'b1, 32'h0040_0024, 32'd0, 32'd0, 1'b1}) begin
        failed++;
        $display("FAIL drop_wait_%0d: got %h want %h", i,
                 {imem_req, imem_addr, PC4_out, Instruction_out, fetch_busy},
                 {1'b1, 32'h0040_0024, 32'd0, 32'd0, 1'b1});
      end
      if (i == 0) tick();
    end
    lat = 1;
    tick();
    tests++;
    if ({imem_req, imem_addr, fetch_busy, Instruction_out} !== {1'b1, 32'h0040_0100, 1'b1, 32'd0}) begin
      failed++;
      $display("FAIL drop_discard: got %h want %h", {imem_req, imem_addr, fetch_busy, Instruction_out},
               {1'b1, 32'h0040_0100, 1'b1, 32'd0});
    end
    tick();
    tests++;
    if ({PC4_out, Instruction_out, fetch_busy} !== {32'h0040_0104, 32'h0040_0100 ^ KEY, 1'b0}) begin
      failed++;
      $display("FAIL drop_target_out: got %h want %h", {PC4_out, Instruction_out, fetch_busy},
               {32'h0040_0104, 32'h0040_0100 ^ KEY, 1'b0});
    end
  endtask

  task automatic test_redirect_stall();
    stall = 1'b1;
    tick();
    tests++;
    if ({imem_req, PC4_out} !== {1'b0, 32'h0040_0104}) begin
      failed++;
      $display("FAIL rs_full: got %h want %h", {imem_req, PC4_out}, {1'b0, 32'h0040_0104});
    end
    redirect        = 1'b1;
    redirect_target = 32'h0040_0200;
    tick();
    redirect = 1'b0;
    tests++;
    if ({imem_req, imem_addr, PC4_out, fetch_busy} !== {1'b1, 32'h0040_0200, 32'd0, 1'b1}) begin
      failed++;
      $display("FAIL rs_flush: got %h want %h", {imem_req, imem_addr, PC4_out, fetch_busy},
               {1'b1, 32'h0040_0200, 32'd0, 1'b1});
    end
    tick();
    tests++;
    if ({PC4_out, Instruction_out, fetch_busy} !== {32'h0040_0204, 32'h0040_0200 ^ KEY, 1'b0}) begin
      failed++;
      $display("FAIL rs_no_resurrect: got %h want %h", {PC4_out, Instruction_out, fetch_busy},
               {32'h0040_0204, 32'h0040_0200 ^ KEY, 1'b0});
    end
    stall = 1'b0;
  endtask

  task automatic test_wrap();
    redirect        = 1'b1;
    redirect_target = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    tests++;
    if ({imem_req, imem_addr, fetch_busy} !== {1'b1, 32'hFFFF_FFF8, 1'b1}) begin
      failed++;
      $display("FAIL wrap_ack_redirect: got %h want %h", {imem_req, imem_addr, fetch_busy},
               {1'b1, 32'hFFFF_FFF8, 1'b1});
    end
    tick();
    tests++;
    if ({PC4_out, Instruction_out, fetch_busy} !== {32'hFFFF_FFFC, 32'hFFFF_FFF8 ^ KEY, 1'b0}) begin
      failed++;
      $display("FAIL wrap_first: got %h want %h", {PC4_out, Instruction_out, fetch_busy},
               {32'hFFFF_FFFC, 32'hFFFF_FFF8 ^ KEY, 1'b0});
    end
    tick();
    tests++;
    if ({PC4_out, Instruction_out, fetch_busy, imem_addr} !==
        {32'd0, 32'hFFFF_FFFC ^ KEY, 1'b0, 32'd0}) begin
      failed++;
      $display("FAIL wrap_around: got %h want %h", {PC4_out, Instruction_out, fetch_busy, imem_addr},
               {32'd0, 32'hFFFF_FFFC ^ KEY, 1'b0, 32'd0});
    end
  endtask

  task automatic test_reset_midtxn();
    auto_mem = 1'b0;
    man_ack  = 1'b0;
    tick();
    tests++;
    if ({imem_req, imem_addr, fetch_busy} !== {1'b1, 32'd0, 1'b1}) begin
      failed++;
      $display("FAIL mid_pending: got %h want %h", {imem_req, imem_addr, fetch_busy},
               {1'b1, 32'd0, 1'b1});
    end
    reset = 1'b0;
    #1;
    tests++;
    if ({imem_req, imem_addr, PC4_out, Instruction_out, fetch_busy} !==
        {1'b0, 32'h0040_0000, 32'd0, 32'd0, 1'b1}) begin
      failed++;
      $display("FAIL mid_async_reset: got %h want %h",
               {imem_req, imem_addr, PC4_out, Instruction_out, fetch_busy},
               {1'b0, 32'h0040_0000, 32'd0, 32'd0, 1'b1});
    end
    man_ack   = 1'b1;
    man_rdata = 32'h1234_5678;
    tick();
    reset = 1'b1;
    tick();
    tests++;
    if ({imem_req, imem_addr, fetch_busy, Instruction_out} !== {1'b1, 32'h0040_0000, 1'b1, 32'd0}) begin
      failed++;
      $display("FAIL mid_ack_ignored: got %h want %h", {imem_req, imem_addr, fetch_busy, Instruction_out},
               {1'b1, 32'h0040_0000, 1'b1, 32'd0});
    end
    man_ack  = 1'b0;
    auto_mem = 1'b1;
    lat      = 1;
    wait_cnt = 0;
    tick();
    tests++;
    if ({PC4_out, Instruction_out, fetch_busy} !== {32'h0040_0004, 32'h0040_0000 ^ KEY, 1'b0}) begin
      failed++;
      $display("FAIL mid_restart: got %h want %h", {PC4_out, Instruction_out, fetch_busy},
               {32'h0040_0004, 32'h0040_0000 ^ KEY, 1'b0});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    test_reset();
    test_stream();
    test_stall();
    test_latency();
    test_redirect_drop();
    test_redirect_stall();
    test_wrap();
    test_reset_midtxn();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
IF stage of the 5-stage MIPS pipeline. It owns the PC, issues instruction-memory reads over a req/ack handshake and buffers returned words in a 2-entry instruction queue. It presents {PC+4, instruction} to the IF/ID register every cycle. IF/ID has no enable, so stalls are realised here: the head entry is held stable on the outputs, and IF/ID re-captures the same value.

Parameters:
RESET_PC, 32'h0040_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0000, bubble instruction driven when the queue is empty

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-low reset
stall  in  1  hazard unit: hold the head entry, do not pop
redirect  in  1  taken branch/jump from ID, one-cycle pulse
redirect_target  in  32  new fetch address, valid with redirect
imem_req  out  1  read request, held until acked
imem_addr  out  32  read address, stable while imem_req=1
imem_ack  in  1  read data valid; completes transaction
imem_rdata  in  32  instruction word, valid with imem_ack
PC4_out  out  32  head PC+4 to IF/ID
Instruction_out  out  32  head instruction to IF/ID
fetch_busy  out  1  1 when the queue is empty (bubble being emitted)

Behaviour:
- Reset: clk and reset are the only clock/reset; reset is asynchronous and active-low. While reset=0, force: state=START, pc=RESET_PC, count=0, imem_req=0, imem_addr=RESET_PC, PC4_out=0, Instruction_out=NOP_INSTR, fetch_busy=1. Reset mid-transaction abandons it; any ack that arrives later is ignored.
- Outputs depend only on registers; there is no combinational path from inputs to outputs.
- States:
  - START: one cycle after reset release, then FETCH.
  - FETCH: normal fetching.
  - DROP: waiting out a stale transaction.
- Handshake:
  - A transaction completes on a clock edge with imem_req=1 and imem_ack=1. An ack in the same cycle as the req rising is legal.
  - imem_ack with imem_req=0 is ignored.
  - Only one transaction is outstanding at a time.
- Request rule: in FETCH, raise imem_req with imem_addr=pc only when count<2. Once raised, req and addr stay stable until ack.
- On a completed ack in FETCH without redirect:
  - push {pc+4, rdata}; pc <= pc+4.
  - imem_req stays 1 next cycle if post-update count<2, else drops to 0.
- Pop: when count>0 and stall=0, remove the head. Push and pop in the same cycle keep count unchanged. Queue order is FIFO.
- Outputs:
  - count>0: PC4_out=head.pc4, Instruction_out=head.instr, fetch_busy=0.
  - count=0: PC4_out=0, Instruction_out=NOP_INSTR, fetch_busy=1.
- Redirect (priority over stall and ack):
  - The current head is treated as the delay-slot instruction. It has been captured by IF/ID this cycle and counts as delivered, even if stall=1.
  - All other entries are flushed; count <= 0; pc <= redirect_target.
  - No transaction outstanding, or ack in the same cycle: the ack data is discarded and the FSM goes to FETCH at the target next cycle.
  - Transaction outstanding and no ack this cycle: go to DROP. Keep req/addr unchanged until ack, discard that data, then go to FETCH at the target.
  - Redirect while in DROP: latest target wins; stay in DROP.
- Address arithmetic: 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0). The low 2 bits of redirect_target are forced to 0.
- Latency: ack at edge n → instruction on outputs during cycle n+1 → captured by IF/ID at edge n+2.

Decomposition:
- Shared pipeline package holds NOP_INSTR, RESET_PC, the fetch-state enum {START, FETCH, DROP} and a fetch-entry struct {pc4[31:0], instr[31:0]}.
- One natural sub-module: fetch_queue, a 2-entry FIFO with push/pop/flush, count and head outputs. The FSM, PC register and handshake stay in fetch_stage.

Test Plan:
- Reset, then a memory that acks on the same cycle as req → imem_addr sequence 0x00400000, 0x00400004, …; outputs 0x00400004/word0 then one new entry per cycle; fetch_busy=0 from the second cycle on.
- stall=1 for 3 cycles with the queue full → imem_req=0; outputs frozen on the same PC4/instruction; on release, entries pop in order with no loss or duplication.
- Memory latency 3 cycles → two bubble cycles (Instruction_out=0, fetch_busy=1) between consecutive instructions; imem_addr stable while waiting.
- Redirect to 0x00400100 with a transaction outstanding to 0x00400008 → FSM enters DROP; the 0x00400008 data is never output; the next request is 0x00400100; the first post-redirect output is PC4=0x00400104.
- Redirect and stall in the same cycle with count=2 → count goes to 0; the next request is the target; the stall does not resurrect the flushed entry.
- Assert reset for one cycle while req is pending, then ack the next cycle → ack ignored; fetch restarts at 0x00400000 after the START cycle.
